// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time transition helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 16;

    typedef logic [MAX_PAT_LEN-1:0] pat_t;
    typedef logic [3:0]             st_idx_t;

    function automatic int state_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Longest pattern prefix that is a suffix of (matched prefix k + bit b);
    // on a full match the candidate is capped at len-1, giving the overlap state.
    function automatic int next_state(
        input pat_t    pattern,
        input int      len,
        input st_idx_t k,
        input logic    b
    );
        int   n;
        int   maxm;
        int   res;
        int   j;
        logic ok;
        logic found;
        logic sj;
        n     = int'(k) + 1;
        maxm  = (n < len) ? n : len - 1;
        res   = 0;
        found = 1'b0;
        for (int m = MAX_PAT_LEN; m >= 1; m--) begin
            if (!found && m <= maxm) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < m) begin
                        j  = n - m + i;
                        sj = (j < int'(k)) ? pattern[4'(len - 1 - j)] : b;
                        if (pattern[4'(len - 1 - i)] != sj)
                            ok = 1'b0;
                    end
                end
                if (ok) begin
                    res   = m;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational (state, in) -> (next, match) lookup built from an elaborated table.
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter pat_t PATTERN = pat_t'(2'b11),
    parameter int   PAT_LEN = 2,
    parameter int   SW      = state_w(PAT_LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          in,
    output logic [SW-1:0] next,
    output logic          match
);

    localparam int NENT = 2 ** (SW + 1);

    logic [SW-1:0]   ns_tbl [NENT];
    logic [NENT-1:0] mt_tbl;

    for (genvar s = 0; s < 2 ** SW; s++) begin : g_st
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (s < PAT_LEN) begin : g_live
                localparam int NS = next_state(PATTERN, PAT_LEN, st_idx_t'(s), 1'(b));
                assign ns_tbl[s*2+b] = SW'(NS);
                assign mt_tbl[s*2+b] = (s == PAT_LEN - 1) && (1'(b) == PATTERN[0]);
            end else begin : g_dead
                // Encodings past the last state fall back to S0 without matching
                assign ns_tbl[s*2+b] = '0;
                assign mt_tbl[s*2+b] = 1'b0;
            end
        end
    end

    assign next  = ns_tbl[{state, in}];
    assign match = mt_tbl[{state, in}];

endmodule

// File: rtl/state_machine_mealy.sv
// Mealy serial pattern detector with overlap; SEQ_DET_MATCH_CNT_EN adds a
// saturating match_count output.
module state_machine_mealy
    import seq_det_pkg::*;
#(
    parameter pat_t PATTERN = pat_t'(2'b11),
    parameter int   PAT_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
    output logic        out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [15:0] match_count
`endif
);

    localparam int SW = state_w(PAT_LEN);

    if (PAT_LEN < 1 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $error("state_machine_mealy: PAT_LEN must be 1..16");
    end

    logic [SW-1:0] state;
    logic [SW-1:0] nxt;
    logic          match;

    seq_det_next_state #(
        .PATTERN (PATTERN),
        .PAT_LEN (PAT_LEN),
        .SW      (SW)
    ) u_ns (
        .state (state),
        .in    (in),
        .next  (nxt),
        .match (match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= '0;
        else
            state <= nxt;
    end

    assign out = match & reset;

`ifdef SEQ_DET_MATCH_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match_count <= '0;
        else if (out && match_count != 16'hFFFF)
            match_count <= match_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_state_machine_mealy.sv
// Randomized check of four detector instances against a bit-history model.
module tb_state_machine_mealy;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in = 1'b0;
    logic o0, o1, o2, o3;
    logic [3:0] outs;

    int n_chk = 0;
    int n_fail = 0;
    bit hist[$];

    localparam logic [15:0] PAT [4] = '{16'b11, 16'b101, 16'b1101101, 16'b0};
    localparam int          LEN [4] = '{2, 3, 7, 1};

    always #5 clk = ~clk;

    assign outs = {o3, o2, o1, o0};

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [15:0] match_count;
    int cnt_m = 0;
    state_machine_mealy u0 (.clk(clk), .reset(reset), .in(in), .out(o0),
                            .match_count(match_count));
`else
    state_machine_mealy u0 (.clk(clk), .reset(reset), .in(in), .out(o0));
`endif
    state_machine_mealy #(16'b101, 3)     u1 (.clk(clk), .reset(reset), .in(in), .out(o1));
    state_machine_mealy #(16'b1101101, 7) u2 (.clk(clk), .reset(reset), .in(in), .out(o2));
    state_machine_mealy #(16'b0, 1)       u3 (.clk(clk), .reset(reset), .in(in), .out(o3));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // A match is simply: the last LEN bits seen since reset, ending with cur, equal the pattern.
    function automatic logic model(input int p, input logic cur);
        int l;
        l = LEN[p];
        if (hist.size() < l - 1) return 1'b0;
        if (cur != PAT[p][0]) return 1'b0;
        for (int i = 1; i < l; i++)
            if (hist[hist.size() - i] != PAT[p][i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_model();
        hist.delete();
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_m = 0;
`endif
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic step(input logic b, input bit pulse, input bit rel);
        logic [3:0] exp;
        @(posedge clk);
        #1;
        if (rel) begin
            reset = 1'b1;
            clear_model();
        end
        in = b;
        if (pulse) begin
            #1 reset = 1'b0;
            #1 check("rst_pulse_out", {12'b0, outs}, 16'h0);
            reset = 1'b1;
            clear_model();
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++)
            exp[p] = reset ? model(p, b) : 1'b0;
        check("out_p11",  {15'b0, o0}, {15'b0, exp[0]});
        check("out_p101", {15'b0, o1}, {15'b0, exp[1]});
        check("out_p7",   {15'b0, o2}, {15'b0, exp[2]});
        check("out_p1",   {15'b0, o3}, {15'b0, exp[3]});
`ifdef SEQ_DET_MATCH_CNT_EN
        check("match_count", match_count, 16'(cnt_m));
        if (exp[0] && cnt_m < 65535) cnt_m++;
`endif
        if (reset) begin
            hist.push_back(b);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic run_seq(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0, 1'b0);
    endtask

    initial begin
        // Held in reset with a toggling input: every output stays low
        clear_model();
        for (int i = 0; i < 6; i++) step(logic'(i % 2), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run_seq(16'b0110110011_0, 11);

        assert_reset();
        step(1'b1, 1'b0, 1'b1);
        run_seq(16'b111, 3);

        assert_reset();
        step(1'b1, 1'b0, 1'b1);
        run_seq(16'b0101, 4);

        assert_reset();
        step(1'b1, 1'b0, 1'b1);
        run_seq(16'b00101, 5);

        // Reset pulsed between edges in the middle of a 1,1 match
        assert_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), 1'b0);

        // Repeats of the 7-bit pattern with its overlapping tail
        for (int r = 0; r < 4; r++) run_seq(16'b1101101, 7);
        run_seq(16'b101101101, 9);

`ifdef SEQ_DET_MATCH_CNT_EN
        assert_reset();
        step(1'b1, 1'b0, 1'b1);
        run_seq(16'b0110101100, 10);
        for (int i = 0; i < 65600; i++) step(1'b1, 1'b0, 1'b0);
        check("match_count_sat", match_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
